// File: rtl/write_buffer_if.sv
// Cache-side and memory-side bus of the write-back buffer.
// The slave view belongs to the buffer. The master view belongs to whatever
// drives the cache requests and models main memory.
interface write_buffer_if #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 128
);
  // cache side
  logic [PA_WIDTH-1:0]  c_addr;
  logic                 c_rd_en;
  logic                 c_wr_en;
  logic [BLK_WIDTH-1:0] c_wr_blk;
  logic [BLK_WIDTH-1:0] c_rd_blk;
  logic                 c_rdy;

  // memory side
  logic [PA_WIDTH-1:0]  m_addr;
  logic                 m_rd_en;
  logic                 m_wr_en;
  logic [BLK_WIDTH-1:0] m_wr_blk;
  logic [BLK_WIDTH-1:0] m_rd_blk;

  modport slave (
    input  c_addr, c_rd_en, c_wr_en, c_wr_blk, m_rd_blk,
    output c_rd_blk, c_rdy, m_addr, m_rd_en, m_wr_en, m_wr_blk
  );

  modport master (
    output c_addr, c_rd_en, c_wr_en, c_wr_blk, m_rd_blk,
    input  c_rd_blk, c_rdy, m_addr, m_rd_en, m_wr_en, m_wr_blk
  );
endinterface

// File: rtl/write_buffer.sv
// write_buffer: a small associative FIFO of dirty blocks that sits between the
// cache's memory-side port and main memory.
// - Evictions are absorbed into the FIFO, and a write to a block that is
//   already buffered is coalesced into the existing entry.
// - A read that matches a buffered block is answered from the FIFO. A read
//   that does not match is forwarded to memory.
// - While the cache is quiet, the head entry is drained to memory, one block
//   per visit to DRAIN.
module write_buffer #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 128,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  write_buffer_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int OFF   = $clog2(BLK_WIDTH / 8);
  localparam int TAG_W = PA_WIDTH - OFF;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RD,
    RD_WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  // FIFO storage. The valid bits qualify the tag match, and the pointers wrap
  // naturally because DEPTH is a power of two.
  logic [TAG_W-1:0]     tag_mem  [DEPTH];
  logic [BLK_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]     valid;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;

  // Block address of the current request. The offset bits only matter to the
  // cache, so they are folded into a deliberately unused signal.
  logic [TAG_W-1:0] req_tag;
  logic             unused_offset;

  assign req_tag       = bus.c_addr[PA_WIDTH-1:OFF];
  assign unused_offset = ^bus.c_addr[OFF-1:0];

  // Per-cycle actions decoded by the FSM.
  logic push;
  logic pop;
  logic coalesce;
  logic load_hit;
  logic load_mem;

  // Associative lookup of the request block address.
  logic             match_any;
  logic [PTR_W-1:0] match_idx;

  // Tag compare against every valid entry. Coalescing keeps tags unique, so at
  // most one entry can match and the first match found is the only one.
  // NOTE: every always_comb output gets a default before any branch; a path that leaves one unassigned infers a latch.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!match_any && valid[i] && (tag_mem[i] == req_tag)) begin
        match_any = 1'b1;
        match_idx = PTR_W'(i);
      end
    end
  end

  // State register. A reset drops any in-flight read, so no c_rdy follows.
  // NOTE: clocked blocks use non-blocking assignments so that every register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and action decode. Cache requests are sampled only in IDLE.
  // A read has priority over a write. An unserved write (full buffer, no
  // match) stays pending at the cache and is retried after one drain.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    coalesce   = 1'b0;
    load_hit   = 1'b0;
    load_mem   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.c_rd_en) begin
          if (match_any) begin
            load_hit   = 1'b1;
            state_next = RESP;
          end else begin
            state_next = RD;
          end
        end else if (bus.c_wr_en) begin
          if (match_any) begin
            coalesce   = 1'b1;
            state_next = RESP;
          end else if (!full) begin
            push       = 1'b1;
            state_next = RESP;
          end else begin
            state_next = DRAIN;
          end
        end else if (!empty) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        pop        = 1'b1;
        state_next = IDLE;
      end
      RD: begin
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        load_mem   = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory-port and completion outputs. These decode directly from the state,
  // so they are all zero in IDLE, and therefore also straight after reset.
  always_comb begin
    bus.m_rd_en  = (state == RD);
    bus.m_wr_en  = (state == DRAIN);
    bus.c_rdy    = (state == RESP);
    bus.m_addr   = '0;
    bus.m_wr_blk = '0;
    if (state == DRAIN) begin
      bus.m_addr   = {tag_mem[head], {OFF{1'b0}}};
      bus.m_wr_blk = data_mem[head];
    end else if (state == RD) begin
      bus.m_addr   = {req_tag, {OFF{1'b0}}};
    end
  end

  // FIFO control: valid bits, pointers, the occupancy count and its flags.
  // The flags are registered next to the count, so all three move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (push) begin
      valid[tail] <= 1'b1;
      tail        <= tail + PTR_ONE;
      count       <= count + CNT_ONE;
      full        <= (count == CNT_LAST);
      empty       <= 1'b0;
    end else if (pop) begin
      valid[head] <= 1'b0;
      head        <= head + PTR_ONE;
      count       <= count - CNT_ONE;
      full        <= 1'b0;
      empty       <= (count == CNT_ONE);
    end
  end

  // Entry payload. A push writes a new tag and block at the tail. A coalesce
  // overwrites only the data of the matching entry.
  // NOTE: the tag/data arrays have no reset; the valid bits alone decide whether an entry means anything.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (push) begin
        tag_mem[tail]  <= req_tag;
        data_mem[tail] <= bus.c_wr_blk;
      end else if (coalesce) begin
        data_mem[match_idx] <= bus.c_wr_blk;
      end
    end
  end

  // Read-return register. It is loaded from the matching entry on a hit, or
  // from memory in RD_WAIT, and is held steady through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.c_rd_blk <= '0;
    end else if (load_hit) begin
      bus.c_rd_blk <= data_mem[match_idx];
    end else if (load_mem) begin
      bus.c_rd_blk <= bus.m_rd_blk;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Directed testbench for write_buffer.
// - Each request pushes its expected completion into a queue.
// - Each scenario pushes its expected memory writes and reads into queues.
// - A negedge monitor pops and compares these whenever the DUT asserts c_rdy,
//   m_wr_en or m_rd_en.
module tb_write_buffer;

  localparam int PA  = 32;
  localparam int BLK = 128;

  typedef struct {
    bit              is_read;
    logic [BLK-1:0]  blk;
    int              cnt;
    bit              full_e;
    int              cyc;
  } rdy_exp_t;

  typedef struct {
    logic [PA-1:0]   addr;
    logic [BLK-1:0]  data;
    int              cyc;
  } mem_exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] count;
  logic       full;
  logic       empty;

  write_buffer_if #(.PA_WIDTH(PA), .BLK_WIDTH(BLK)) bus ();

  write_buffer #(.PA_WIDTH(PA), .BLK_WIDTH(BLK), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  rdy_exp_t exp_rdy [$];
  mem_exp_t exp_mw  [$];
  mem_exp_t exp_mrd [$];

  logic [BLK-1:0] mem_model [logic [PA-1:0]];
  logic [PA-1:0]  rsp_addr;

  rdy_exp_t mon_r;
  mem_exp_t mon_w;
  mem_exp_t mon_m;

  localparam logic [BLK-1:0] DAT_FA = {16{8'hFA}};
  localparam logic [BLK-1:0] DAT_A  = {4{32'hAAAA_0001}};
  localparam logic [BLK-1:0] DAT_B  = {4{32'hBBBB_0002}};
  localparam logic [BLK-1:0] DAT_C  = {4{32'hCCCC_0003}};
  localparam logic [BLK-1:0] DAT_D  = {4{32'hDDDD_0004}};
  localparam logic [BLK-1:0] DAT_E  = {4{32'hEEEE_0005}};
  localparam logic [BLK-1:0] DAT_F  = {4{32'hF0F0_0006}};
  localparam logic [BLK-1:0] DAT_G  = {4{32'h1357_0007}};
  localparam logic [BLK-1:0] DAT_0  = 128'h0000_0000_1111_1111_2222_2222_3333_3333;
  localparam logic [BLK-1:0] DAT_1  = 128'h4444_4444_5555_5555_6666_6666_7777_7777;
  localparam logic [BLK-1:0] DAT_2  = 128'h8888_8888_9999_9999_AAAA_AAAA_BBBB_BBBB;
  localparam logic [BLK-1:0] DAT_3  = 128'hCCCC_CCCC_DDDD_DDDD_EEEE_EEEE_FFFF_FFFF;
  localparam logic [BLK-1:0] DAT_4  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_mw(input logic [PA-1:0] addr, input logic [BLK-1:0] data, input int at);
    mem_exp_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = at;
    exp_mw.push_back(e);
  endtask

  task automatic push_mrd(input logic [PA-1:0] addr, input int at);
    mem_exp_t e;
    e.addr = addr;
    e.data = '0;
    e.cyc  = at;
    exp_mrd.push_back(e);
  endtask

  // Issue one request and hold it until c_rdy. The task returns #1 into the
  // RESP cycle with the request dropped, so a caller can chain the next one.
  // lat is the hand-computed distance from the issue cycle to c_rdy.
  task automatic req(input bit rd, input logic [PA-1:0] addr, input logic [BLK-1:0] blk,
                     input int lat, input int cnt, input bit full_e);
    rdy_exp_t e;
    int n;
    e.is_read = rd;
    e.blk     = blk;
    e.cnt     = cnt;
    e.full_e  = full_e;
    e.cyc     = cyc + lat;
    exp_rdy.push_back(e);
    bus.c_addr   = addr;
    bus.c_rd_en  = rd;
    bus.c_wr_en  = !rd;
    bus.c_wr_blk = rd ? '0 : blk;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.c_rdy && n < 20);
    if (!bus.c_rdy) check("rdy_timeout", 128'(0), 128'(1));
    bus.c_rd_en = 1'b0;
    bus.c_wr_en = 1'b0;
  endtask

  // Memory model: read data appears in the cycle after m_rd_en.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.m_rd_en === 1'b1) begin
        rsp_addr = bus.m_addr;
        @(posedge clk);
        #1;
        bus.m_rd_blk = mem_model.exists(rsp_addr) ? mem_model[rsp_addr] : '0;
      end
    end
  end

  // Monitor: protocol checks every cycle, plus scoreboard pops on each DUT output event.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("mem_exclusive", 128'(bus.m_rd_en & bus.m_wr_en), 128'(0));
      check("legal_request", 128'(bus.c_rd_en & bus.c_wr_en), 128'(0));
      if (bus.c_rdy === 1'b1) begin
        if (exp_rdy.size() == 0) begin
          check("rdy_unexpected", 128'(1), 128'(0));
        end else begin
          mon_r = exp_rdy.pop_front();
          check("rdy_cycle", 128'(cyc), 128'(mon_r.cyc));
          check("rdy_count", 128'(count), 128'(mon_r.cnt));
          check("rdy_full", 128'(full), 128'(mon_r.full_e));
          if (mon_r.is_read) check("rd_blk", bus.c_rd_blk, mon_r.blk);
        end
      end
      if (bus.m_wr_en === 1'b1) begin
        if (exp_mw.size() == 0) begin
          check("mw_unexpected", 128'(1), 128'(0));
        end else begin
          mon_w = exp_mw.pop_front();
          check("mw_addr", 128'(bus.m_addr), 128'(mon_w.addr));
          check("mw_data", bus.m_wr_blk, mon_w.data);
          check("mw_cycle", 128'(cyc), 128'(mon_w.cyc));
        end
      end
      if (bus.m_rd_en === 1'b1) begin
        if (exp_mrd.size() == 0) begin
          check("mrd_unexpected", 128'(1), 128'(0));
        end else begin
          mon_m = exp_mrd.pop_front();
          check("mrd_addr", 128'(bus.m_addr), 128'(mon_m.addr));
          check("mrd_cycle", 128'(cyc), 128'(mon_m.cyc));
        end
      end
    end
  end

  // Watchdog in case the stimulus itself stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n        = 1'b0;
    bus.c_addr   = 32'h0000_1230;
    bus.c_rd_en  = 1'b0;
    bus.c_wr_en  = 1'b1;
    bus.c_wr_blk = {16{8'h5A}};
    bus.m_rd_blk = '0;
    mem_model[32'h0000_8000] = DAT_D;
    mem_model[32'h0000_3000] = DAT_G;

    // Reset held for two edges with a write asserted: nothing is pushed.
    wait_cyc(2);
    check("rst_count", 128'(count), 128'(0));
    check("rst_empty", 128'(empty), 128'(1));
    check("rst_full", 128'(full), 128'(0));
    check("rst_c_rdy", 128'(bus.c_rdy), 128'(0));
    check("rst_m_rd_en", 128'(bus.m_rd_en), 128'(0));
    check("rst_m_wr_en", 128'(bus.m_wr_en), 128'(0));
    check("rst_c_rd_blk", bus.c_rd_blk, 128'(0));
    check("rst_m_addr", 128'(bus.m_addr), 128'(0));
    check("rst_m_wr_blk", bus.m_wr_blk, 128'(0));
    bus.c_wr_en = 1'b0;
    rst_n       = 1'b1;
    wait_cyc(1);
    check("post_rst_empty", 128'(empty), 128'(1));

    // Write, then drain to the block-aligned address.
    t0 = cyc;
    push_mw(32'h0000_20d0, DAT_FA, t0 + 3);
    req(1'b0, 32'h0000_20d5, DAT_FA, 1, 1, 1'b0);
    wait_cyc(3);
    check("wd_empty", 128'(empty), 128'(1));
    check("wd_count", 128'(count), 128'(0));

    // Coalesce: the second write merges, and a single drain writes B.
    t0 = cyc;
    push_mw(32'h0000_2000, DAT_B, t0 + 5);
    req(1'b0, 32'h0000_2000, DAT_A, 1, 1, 1'b0);
    req(1'b0, 32'h0000_2008, DAT_B, 2, 1, 1'b0);
    wait_cyc(3);
    check("co_empty", 128'(empty), 128'(1));

    // Fill the buffer, then stall on a fifth write. Later drains wrap the pointers.
    t0 = cyc;
    push_mw(32'h0000_0000, DAT_0, t0 + 9);
    push_mw(32'h0000_4000, DAT_1, t0 + 13);
    push_mw(32'h0000_8000, DAT_2, t0 + 15);
    push_mw(32'h0000_C000, DAT_3, t0 + 17);
    push_mw(32'h0001_0000, DAT_4, t0 + 19);
    req(1'b0, 32'h0000_0000, DAT_0, 1, 1, 1'b0);
    req(1'b0, 32'h0000_4000, DAT_1, 2, 2, 1'b0);
    req(1'b0, 32'h0000_8000, DAT_2, 2, 3, 1'b0);
    req(1'b0, 32'h0000_C000, DAT_3, 2, 4, 1'b1);
    req(1'b0, 32'h0001_0000, DAT_4, 4, 4, 1'b1);
    wait_cyc(9);
    check("fill_empty", 128'(empty), 128'(1));
    check("fill_full", 128'(full), 128'(0));
    check("fill_count", 128'(count), 128'(0));

    // A read hit is served from the buffer, with no memory read.
    t0 = cyc;
    push_mw(32'h0000_6000, DAT_C, t0 + 5);
    req(1'b0, 32'h0000_6000, DAT_C, 1, 1, 1'b0);
    req(1'b1, 32'h0000_6004, DAT_C, 2, 1, 1'b0);
    wait_cyc(3);
    check("fwd_empty", 128'(empty), 128'(1));

    // A read miss with two entries buffered goes to memory before any drain.
    t0 = cyc;
    push_mrd(32'h0000_8000, t0 + 5);
    push_mw(32'h0000_A000, DAT_E, t0 + 9);
    push_mw(32'h0000_B000, DAT_F, t0 + 11);
    req(1'b0, 32'h0000_A000, DAT_E, 1, 1, 1'b0);
    req(1'b0, 32'h0000_B000, DAT_F, 2, 2, 1'b0);
    req(1'b1, 32'h0000_8004, DAT_D, 4, 2, 1'b0);
    wait_cyc(5);
    check("miss_empty", 128'(empty), 128'(1));

    // A read miss into an empty buffer, issued from IDLE.
    t0 = cyc;
    push_mrd(32'h0000_3000, t0 + 1);
    req(1'b1, 32'h0000_300c, DAT_G, 3, 0, 1'b0);
    wait_cyc(4);

    check("left_rdy", 128'(exp_rdy.size()), 128'(0));
    check("left_mw", 128'(exp_mw.size()), 128'(0));
    check("left_mrd", 128'(exp_mrd.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
